// File: rtl/vec_pkg.sv
`default_nettype none
// =============================================================================
// vec_pkg : shared element type and read-stream state encoding
// Rev 1.0
// =============================================================================
package vec_pkg;

   localparam int VEC_WIDTH = 10;
   localparam int VEC_DEPTH = 1024;

   typedef logic [VEC_WIDTH-1:0] elem_t;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/vec_lane_gather.sv
`default_nettype none
// =============================================================================
// vec_lane_gather : picks LANES consecutive elements starting at idx, masked by len
// Rev 1.0
// =============================================================================
module vec_lane_gather
   import vec_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int DEPTH = VEC_DEPTH,
   parameter int LANES = 8,
   parameter int IDX_W = $clog2(DEPTH + LANES),
   parameter int LEN_W = $clog2(DEPTH + 1)
) (
   input  logic [DEPTH-1:0][WIDTH-1:0] vec,
   input  logic [IDX_W-1:0]            idx,
   input  logic [LEN_W-1:0]            len,
   output logic [LANES-1:0][WIDTH-1:0] data,
   output logic [LANES-1:0]            keep
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = ((IDX_W > LEN_W) ? IDX_W : LEN_W) + 1;

   genvar j;
   generate
      for (j = 0; j < LANES; j++) begin : g_lane
         logic [CW-1:0] pos;
         assign pos     = CW'(idx) + CW'(j);
         // pos < len <= DEPTH whenever keep is set, so the narrowed address is exact
         assign keep[j] = (pos < CW'(len));
         assign data[j] = keep[j] ? vec[pos[AW-1:0]] : '0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vec_read_stream.sv
`default_nettype none
// =============================================================================
// vec_read_stream : selects one of NSRC vectors and streams a prefix LANES per beat
// Optional stall counter output enabled by VEC_RD_STALL_CNT_EN. Rev 1.0
// =============================================================================
module vec_read_stream
   import vec_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int DEPTH = VEC_DEPTH,
   parameter int NSRC  = 4,
   parameter int LANES = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NSRC-1:0][DEPTH-1:0][WIDTH-1:0] in_vec,
   input  logic                                 req_valid,
   output logic                                 req_ready,
   input  logic [$clog2(NSRC)-1:0]              req_sel,
   input  logic [$clog2(DEPTH+1)-1:0]           req_len,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [LANES-1:0][WIDTH-1:0]          out_data,
   output logic [LANES-1:0]                     out_keep,
   output logic                                 out_last,
   output logic                                 done,
   output logic                                 busy
`ifdef VEC_RD_STALL_CNT_EN
   ,output logic [31:0]                         stall_cnt
`endif
);

   localparam int SEL_W = $clog2(NSRC);
   localparam int LEN_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH + LANES);
   localparam int CW    = ((IDX_W > LEN_W) ? IDX_W : LEN_W) + 1;

   rd_state_e                   state;
   rd_state_e                   state_n;
   logic [IDX_W-1:0]            idx;
   logic [SEL_W-1:0]            sel;
   logic [LEN_W-1:0]            len;
   logic                        done_q;
   logic                        accept;
   logic                        xfer;
   logic                        last_beat;
   logic [SEL_W-1:0]            sel_n;
   logic [LEN_W-1:0]            len_n;
   logic [DEPTH-1:0][WIDTH-1:0] src;

   assign sel_n     = (int'(req_sel) < NSRC) ? req_sel : '0;
   assign len_n     = (req_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : req_len;
   assign last_beat = ((CW'(idx) + CW'(LANES)) >= CW'(len));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      req_ready = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            if (req_valid && (len_n != '0)) begin
               state_n = STREAM;
            end
         end
         STREAM: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            xfer      = out_ready;
            if (out_ready && last_beat) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         sel    <= '0;
         len    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            sel    <= sel_n;
            len    <= len_n;
            idx    <= '0;
            done_q <= (len_n == '0);
         end else if (xfer) begin
            if (last_beat) begin
               idx    <= '0;
               done_q <= 1'b1;
            end else begin
               idx <= idx + IDX_W'(LANES);
            end
         end
      end
   end

   // Source is read live; the caller keeps it stable for the whole request
   assign src      = in_vec[sel];
   assign out_last = out_valid && last_beat;
   assign done     = done_q;

   vec_lane_gather #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LANES (LANES),
      .IDX_W (IDX_W),
      .LEN_W (LEN_W)
   ) u_gather (
      .vec  (src),
      .idx  (idx),
      .len  (len),
      .data (out_data),
      .keep (out_keep)
   );

`ifdef VEC_RD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_read_stream.sv
`default_nettype none
// =============================================================================
// tb_vec_read_stream : directed self-checking bench for vec_read_stream
// Rev 1.0
// =============================================================================
module tb_vec_read_stream;

   localparam int WIDTH = 10;
   localparam int DEPTH = 1024;
   // five sources so that an out-of-range select (5) is representable on req_sel
   localparam int NSRC  = 5;
   localparam int LANES = 8;
   localparam int DW    = LANES * WIDTH;

   logic                                 clk = 1'b0;
   logic                                 rst = 1'b1;
   logic [NSRC-1:0][DEPTH-1:0][WIDTH-1:0] in_vec;
   logic                                 req_valid = 1'b0;
   logic                                 req_ready;
   logic [$clog2(NSRC)-1:0]              req_sel = '0;
   logic [$clog2(DEPTH+1)-1:0]           req_len = '0;
   logic                                 out_valid;
   logic                                 out_ready = 1'b0;
   logic [LANES-1:0][WIDTH-1:0]          out_data;
   logic [LANES-1:0]                     out_keep;
   logic                                 out_last;
   logic                                 done;
   logic                                 busy;
`ifdef VEC_RD_STALL_CNT_EN
   logic [31:0]                          stall_cnt;
`endif

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vec_read_stream #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .NSRC  (NSRC),
      .LANES (LANES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_vec    (in_vec),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sel   (req_sel),
      .req_len   (req_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .done      (done),
      .busy      (busy)
`ifdef VEC_RD_STALL_CNT_EN
      ,.stall_cnt (stall_cnt)
`endif
   );

   // Bank s holds (e + 211*s) mod 1024, distinct across all five banks
   function automatic logic [WIDTH-1:0] exp_elem(input int s, input int e);
      return WIDTH'((e + s * 211) % 1024);
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input int s, input int len);
      req_valid = 1'b1;
      req_sel   = 3'(s);
      req_len   = 11'(len);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic check_beat(input int s, input int idx, input int len, input string tag);
      logic [DW-1:0]    ed;
      logic [LANES-1:0] ek;
      ed = '0;
      ek = '0;
      for (int j = 0; j < LANES; j++) begin
         if (idx + j < len) begin
            ek[j] = 1'b1;
            ed[j*WIDTH +: WIDTH] = exp_elem(s, idx + j);
         end
      end
      chkd({tag, " data"}, out_data, ed);
      chkd({tag, " keep"}, DW'(out_keep), DW'(ek));
      chk1({tag, " last"}, out_last, (idx + LANES >= len));
   endtask

   // Streams a whole request from the cycle after acceptance through the done pulse
   task automatic run_stream(input int s, input int len, input bit toggle, input string tag);
      int idx    = 0;
      int beats  = 0;
      int stalls = 0;
      int cyc    = 0;
      bit fin    = 1'b0;
      bit x;
      chk1({tag, " first valid"}, out_valid, 1'b1);
      while (!fin && cyc < 4000) begin
         out_ready = toggle ? ~cyc[0] : 1'b1;
         x = 1'b0;
         if (out_valid === 1'b1) begin
            check_beat(s, idx, len, tag);
            chk1({tag, " busy"}, busy, 1'b1);
            chk1({tag, " req_ready"}, req_ready, 1'b0);
            chk1({tag, " done early"}, done, 1'b0);
            if (!out_ready) stalls++;
            x = out_ready;
         end else begin
            chk1({tag, " valid dropped"}, out_valid, 1'b1);
            fin = 1'b1;
         end
         tick();
         cyc++;
         if (x) begin
            beats++;
            if (idx + LANES >= len) fin = 1'b1;
            else idx += LANES;
         end
      end
      out_ready = 1'b1;
      chkn({tag, " beats"}, beats, (len + LANES - 1) / LANES);
      chk1({tag, " done pulse"}, done, 1'b1);
      chk1({tag, " bubble"}, out_valid, 1'b0);
`ifdef VEC_RD_STALL_CNT_EN
      chkn({tag, " stall_cnt"}, int'(stall_cnt), stalls);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < NSRC; s++)
         for (int e = 0; e < DEPTH; e++)
            in_vec[s][e] = exp_elem(s, e);

      // reset state
      repeat (3) tick();
      rst = 1'b0;
      chk1("rst req_ready", req_ready, 1'b1);
      chk1("rst out_valid", out_valid, 1'b0);
      chk1("rst busy", busy, 1'b0);
      chk1("rst done", done, 1'b0);
      chk1("rst out_last", out_last, 1'b0);

      // sel 2, len 20: three back-to-back beats, last one partial
      out_ready = 1'b1;
      request(2, 20);
      chk1("t1 b1 valid", out_valid, 1'b1);
      chkd("t1 b1 lane0", DW'(out_data[0]), DW'(422));
      check_beat(2, 0, 20, "t1 b1");
      tick();
      check_beat(2, 8, 20, "t1 b2");
      tick();
      chkd("t1 b3 keep", DW'(out_keep), DW'(8'h0F));
      chkd("t1 b3 lane0", DW'(out_data[0]), DW'(438));
      chkd("t1 b3 lane3", DW'(out_data[3]), DW'(441));
      chkd("t1 b3 lane7", DW'(out_data[7]), DW'(0));
      chk1("t1 b3 last", out_last, 1'b1);
      check_beat(2, 16, 20, "t1 b3");
      tick();
      chk1("t1 done", done, 1'b1);
      chk1("t1 idle valid", out_valid, 1'b0);
      tick();
      chk1("t1 done once", done, 1'b0);

      // zero-length request
      request(1, 0);
      chk1("t2 valid", out_valid, 1'b0);
      chk1("t2 done", done, 1'b1);
      chk1("t2 req_ready", req_ready, 1'b1);
      tick();
      chk1("t2 done once", done, 1'b0);
      chk1("t2 req_ready2", req_ready, 1'b1);

      // full-length request with toggling ready
      request(1, 1024);
      run_stream(1, 1024, 1'b1, "t3");
      tick();

      // bank 3, with a second request held during STREAM
      request(3, 16);
      chkd("t4 lane0", DW'(out_data[0]), DW'(633));
      req_valid = 1'b1;
      req_sel   = 3'd0;
      req_len   = 11'd8;
      run_stream(3, 16, 1'b0, "t4");
      chk1("t4 req_ready at done", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      run_stream(0, 8, 1'b0, "t4b");
      tick();

      // reset in the middle of a len=64 request
      request(1, 64);
      check_beat(1, 0, 64, "t5 b1");
      tick();
      check_beat(1, 8, 64, "t5 b2");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("t5 valid", out_valid, 1'b0);
      chk1("t5 busy", busy, 1'b0);
      chk1("t5 req_ready", req_ready, 1'b1);
      chk1("t5 done", done, 1'b0);
      tick();
      chk1("t5 done later", done, 1'b0);
      request(1, 8);
      run_stream(1, 8, 1'b0, "t5b");
      tick();

      // over-long length clamps to DEPTH, out-of-range select maps to bank 0
      request(5, 2000);
      chkd("t6 lane5", DW'(out_data[5]), DW'(5));
      run_stream(0, 1024, 1'b0, "t6");
      tick();

      // reset wins over a simultaneous request
      rst       = 1'b1;
      req_valid = 1'b1;
      req_sel   = 3'd1;
      req_len   = 11'd8;
      tick();
      rst       = 1'b0;
      req_valid = 1'b0;
      chk1("t7 valid", out_valid, 1'b0);
      chk1("t7 busy", busy, 1'b0);
      tick();
      chk1("t7 done", done, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
